// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - shared op encodings, FSM states and helpers for hilo_muldiv
package hilo_muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MADDU = 3'b100,
    OP_MADD  = 3'b101,
    OP_MSUBU = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - unsigned radix-2 shift-add multiplier / restoring divider
// Multiply leaves the product in {hi,lo}; divide leaves remainder in hi, quotient in lo.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] mag_a_i,
  input  logic [WIDTH-1:0] mag_b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  always_comb begin
    sr_d    = sr_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    add_sum = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh  = sr_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opnd_q};

    if (load_i) begin
      sr_d   = {{WIDTH{1'b0}}, mag_a_i};
      opnd_d = mag_b_i;
      div_d  = is_div_i;
      cnt_d  = CW'(WIDTH);
    end else if (step_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        // diff[WIDTH] set means the trial subtraction borrowed: restore.
        if (!diff[WIDTH]) begin
          sr_d = {diff[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
        end else begin
          sr_d = {rem_sh[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b0};
        end
      end else if (sr_q[0]) begin
        sr_d = {add_sum, sr_q[WIDTH-1:1]};
      end else begin
        sr_d = {1'b0, sr_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign hi_o   = sr_q[2*WIDTH-1:WIDTH];
  assign lo_o   = sr_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - multi-cycle HI/LO multiply/divide unit with stall, annul and accumulate
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     quot, rem;
  logic [2*WIDTH-1:0]   prod, prod_s, mul_res;
  logic                 core_last;
  logic [WIDTH-1:0]     core_hi, core_lo;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .step_i   (state_q == ST_CALC),
    .is_div_i (op_is_div(op_i)),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .last_o   (core_last),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  always_comb begin
    accept  = (state_q == ST_IDLE) & start_i & ~annul_i;
    a_neg   = op_is_signed(op_i) & opa_i[WIDTH-1];
    b_neg   = op_is_signed(op_i) & opb_i[WIDTH-1];
    mag_a   = a_neg ? -opa_i : opa_i;
    mag_b   = b_neg ? -opb_i : opb_i;

    // Signed fix-up: quotient/product follow sign XOR, remainder follows dividend.
    prod    = {core_hi, core_lo};
    prod_s  = neg_res_q ? -prod : prod;
    quot    = neg_res_q ? -core_lo : core_lo;
    rem     = neg_rem_q ? -core_hi : core_hi;
    if (op_is_sub(op_q)) begin
      mul_res = acc_q - prod_s;
    end else if (op_is_acc(op_q)) begin
      mul_res = acc_q + prod_s;
    end else begin
      mul_res = prod_s;
    end

    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;

    if (annul_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d      = op_i;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            acc_d     = {hi_i, lo_i};
            if (op_is_div(op_i) && opb_i == '0) begin
              state_d = ST_DONE;
              hi_d    = opa_i;
              lo_d    = '1;
              dz_d    = 1'b1;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (core_last) state_d = ST_SIGN;
        end
        ST_SIGN: begin
          state_d = ST_DONE;
          dz_d    = 1'b0;
          if (op_is_div(op_q)) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign stall_o    = accept | (state_q == ST_CALC) | (state_q == ST_SIGN);
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multi-cycle multiply/divide unit for the CPU execute stage, producing HI/LO results. Handles signed/unsigned multiply, multiply-accumulate/subtract and divide as iterative radix-2 operations. Stalls the pipeline while busy and supports annulment on exception flush. Its results are written into the HI/LO registers by the existing writeback path.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4, even)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- op_i  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADDU, 101 MADD, 110 MSUBU, 111 MSUB (bit0 = signed)
- opa_i  in  WIDTH  rs operand / dividend
- opb_i  in  WIDTH  rt operand / divisor
- hi_i, lo_i  in  WIDTH each  current HI/LO, accumulator for MADD*/MSUB*
- annul_i  in  1  abort current/pending operation
- stall_o  out  1  pipeline stall request
- done_o  out  1  one-cycle result-valid pulse
- hi_o, lo_o  out  WIDTH each  result; held until next accepted start
- div_zero_o  out  1  valid with done_o; divide with opb_i == 0

## Operation
- States: IDLE, CALC, SIGN, DONE. Reset: IDLE, all outputs 0.
- IDLE: start_i & !annul_i → capture op, operands, accumulator; convert signed operands to magnitude, record result signs; → CALC; counter = WIDTH.
- DIV*/DIVU* with opb_i == 0: → DONE directly; lo_o = all ones, hi_o = opa_i, div_zero_o = 1.
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements; at 0 → SIGN.
- SIGN: negate product if signs differ (signed ops); quotient negated if signs differ, remainder takes dividend sign; MADD*: {hi,lo} = {hi_i,lo_i} + product; MSUB*: {hi_i,lo_i} − product; 2·WIDTH modular arithmetic, no overflow flag → DONE.
- DONE: done_o = 1, hi_o/lo_o valid → IDLE.
- Multiply: {hi_o,lo_o} = 2·WIDTH-bit product. Divide: lo_o = quotient, hi_o = remainder.
- DIV of most-negative by −1: lo_o = most-negative (wrap), hi_o = 0.
- annul_i in any state → IDLE next edge, no done_o, hi_o/lo_o keep last value. annul_i with start_i in IDLE: annul wins.
- start_i outside IDLE ignored (upstream holds it under stall).

## Timing
- stall_o = (IDLE & start_i & !annul_i) | CALC | SIGN; low in DONE and for the divide-by-zero path's DONE.
- Latency: start cycle = 0; done_o high in cycle WIDTH+2 (34 for WIDTH=32). Divide-by-zero: cycle 1.
- done_o is registered; hi_o/lo_o/div_zero_o change only on the edge entering DONE.
- Back-to-back: new start_i accepted in the cycle after DONE (IDLE); minimum start spacing WIDTH+3.
- rst mid-operation: immediate return to IDLE, outputs 0.

## Structure
- Shared package: op_i encodings, state encoding, WIDTH default constant.
- Sub-module muldiv_iter_core: magnitude datapath (2·WIDTH shift register, adder/subtractor, step counter); top handles FSM, sign fix-up, accumulate, handshake.

## Test plan
- MULT opa=0xFFFFFFFB, opb=6 → done_o at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFE2; stall_o high cycles 0–33.
- MADDU hi_i=0, lo_i=0xFFFFFFE2, opa=opb=0x10000 → hi=0x00000001, lo=0xFFFFFFE2; MSUB hi_i=0x5, lo_i=0, opa=opb=2 → hi=0x4, lo=0xFFFFFFFC.
- DIV opa=0xFFFFFFF9 (−7), opb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0x80000010/0x10 → lo=0x08000001, hi=0.
- DIVU opa=0x12345678, opb=0 → done_o at cycle 1, lo=0xFFFFFFFF, hi=0x12345678, div_zero_o=1, stall_o high only cycle 0.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_zero_o=0.
- MULT started, annul_i at cycle 10 → state IDLE cycle 11, no done_o, hi_o/lo_o unchanged; new MULTU 3×5 then → hi=0, lo=0xF; rst asserted mid-CALC → all outputs 0 immediately.
